sram_1rw_arbiter: RTL and testbench
===================================

Name: sram_1rw_arbiter

Overview:
- Shares one single-port 1RW SRAM macro (CEB/WEB active-low, 1-cycle read latency, Q undefined on non-read cycles) between a write requester and a read requester.
- Arbitrates with write priority bounded by a starvation limit.
- Captures the macro Q into a skid register so read responses tolerate backpressure.
- Optionally zero-fills the array after reset. Sits between pipeline logic and the 32x80 macro.

Parameters:
DATA_W, 80, data width
ADDR_W, 5, address width
DEPTH, 32, number of words (at most 2**ADDR_W)
STARVE_MAX, 4, consecutive write grants tolerated while a read waits

Ports:
CLK  input  1  clock; all logic on posedge
RSTB  input  1  asynchronous active-low reset
wr_valid  input  1  write request
wr_ready  output  1  write accepted this cycle
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
rd_valid  input  1  read request
rd_ready  output  1  read accepted this cycle
rd_addr  input  ADDR_W  read address
rsp_valid  output  1  read data valid
rsp_ready  input  1  consumer accepts rsp_data
rsp_data  output  DATA_W  read data
init_done  output  1  array usable
sram_ceb  output  1  macro chip enable, active-low
sram_web  output  1  macro write enable, active-low (1 = read)
sram_a  output  ADDR_W  macro address
sram_d  output  DATA_W  macro write data
sram_q  input  DATA_W  macro read data

Behaviour:
- Clocking and reset: one clock, CLK; reset RSTB is asynchronous, active-low.
- Reset values: rsp_valid=0, init_done=0 (macro on) or 1 (macro off), wr_ready=0, rd_ready=0, sram_ceb=1, sram_web=1, and internal state idle. An in-flight read is discarded, as is held data.
- Macro outputs are combinational from the current-cycle grant. Idle cycle: sram_ceb=1, sram_web=1, sram_a=0, sram_d=0.
- State machine: INIT -> RUN. In RUN, requesters are served.
- Handshake: a transfer occurs when valid && ready. A requester holds its valid until ready.
- Write grant: sram_ceb=0, sram_web=0, sram_a=wr_addr, sram_d=wr_data. The write is complete at that edge.
- Read grant at cycle T: sram_ceb=0, sram_web=1, sram_a=rd_addr. The inflight flag is set for T+1.
- Response path:
  - rsp_valid = hold_v | inflight; rsp_data = hold_v ? hold_q : sram_q.
  - If inflight && !rsp_ready: capture sram_q into hold_q and set hold_v.
  - hold_v clears on rsp_ready.
  - Never sample sram_q on non-inflight cycles.
- Read eligibility: rd_can = (!hold_v && !inflight) || rsp_ready. rd_ready depends combinationally on rsp_ready. Back-to-back reads give 1 response/cycle when rsp_ready=1.
- Arbitration:
  - Write wins by default.
  - Counter wstreak (width clog2(STARVE_MAX+1)) increments on a write grant while rd_valid=1 and rd_can=1. It resets on a read grant or when rd_valid=0.
  - When wstreak==STARVE_MAX and rd_can, the read wins and the write waits.
  - Only one grant per cycle.
- Ordering: the grant order is the array order. A read granted after a same-address write returns the new data.
- Addresses >= DEPTH: behaviour is undefined and not checked.
- Reset mid-operation: the response in progress is dropped and INIT restarts (when enabled).

Optional Feature:
- Macro SRAM_ARB_INIT_EN.
- Defined:
  - After reset, the block is in INIT. It writes DATA_W'0 to addresses 0..DEPTH-1, one per cycle, for DEPTH cycles.
  - During INIT, wr_ready=0 and rd_ready=0.
  - init_done rises the cycle after the last init write, and the block enters RUN.
- Undefined: the block starts in RUN, init_done=1 from reset release, and there is no INIT logic.

Test Plan:
- Write 0xA5 to addr 3, then read addr 3 with rsp_ready=1 -> rsp_valid at T+1, rsp_data=0xA5, sram_ceb/web per grant.
- Reads addr 0..7 back-to-back, rsp_ready=1 -> 8 consecutive rsp_valid cycles, data in order. Drop rsp_ready for 3 cycles mid-burst -> the held word is stable, rd_ready=0, and no data is lost or duplicated.
- wr_valid and rd_valid both held high, STARVE_MAX=4 -> grant pattern W,W,W,W,R repeating.
- Same-cycle write addr 5=0x1 and read addr 5 (old 0x0) -> write first, read returns 0x1.
- SRAM_ARB_INIT_EN defined -> 32 zero-writes with sram_a 0..31, init_done at cycle 33, then a read of any address returns 0. Undefined -> init_done=1 right after reset.
- Assert RSTB low while a read is inflight with rsp_ready=0 -> rsp_valid=0 immediately and sram_ceb=1. With SRAM_ARB_INIT_EN defined, INIT restarts on release.

Source files
------------

// File: rtl/sram_1rw_arbiter.sv
// sram_1rw_arbiter: shares one single-port 1RW SRAM macro (CEB/WEB active-low,
// 1-cycle read latency) between a write requester and a read requester.
//
// Arbitration: writes win by default. A pending, eligible read is forced through
// after STARVE_MAX consecutive write grants.
//
// Read responses: macro Q is passed through combinationally in the cycle after
// the read grant. If the consumer stalls, Q is captured into a one-entry skid
// register.
//
// Handshakes: a transfer happens on a cycle where valid && ready. A requester
// keeps valid (and its address/data) stable until it sees ready. rd_ready
// depends combinationally on rsp_ready. rsp_valid/rsp_data follow the same
// rule towards the consumer.
//
// Optional feature macro: SRAM_ARB_INIT_EN.
// When it is defined, the block zero-fills addresses 0..DEPTH-1 after reset
// before serving requests. When it is undefined, the block serves requests
// from reset release.
//
// dbg_state exposes the controller state (0 = INIT, 1 = RUN).
module sram_1rw_arbiter #(
    parameter int DATA_W     = 80,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RSTB,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              init_done,
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q,
    output logic [0:0]        dbg_state
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

    if (DEPTH > (1 << ADDR_W)) begin : g_depth_check
        $error("DEPTH does not fit in ADDR_W address bits");
    end

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state;
    logic              init_wr;
    logic [ADDR_W-1:0] init_addr;

`ifdef SRAM_ARB_INIT_EN
    localparam logic [ADDR_W-1:0] INIT_LAST = ADDR_W'(DEPTH - 1);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] init_cnt_q;
    logic [ADDR_W-1:0] init_cnt_d;

    // INIT walks the address counter once over the array, then hands over to RUN.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == INIT_LAST) begin
                state_d    = ST_RUN;
                init_cnt_d = '0;
            end
        end
    end

    // State register and zero-fill address counter.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    assign state     = state_q;
    assign init_wr   = RSTB && (state_q == ST_INIT);
    assign init_addr = init_cnt_q;
`else
    assign state     = ST_RUN;
    assign init_wr   = 1'b0;
    assign init_addr = '0;
`endif

    logic              hold_v_q;
    logic              hold_v_d;
    logic [DATA_W-1:0] hold_data_q;
    logic [DATA_W-1:0] hold_data_d;
    logic              inflight_q;
    logic              inflight_d;
    logic [SW-1:0]     wstreak_q;
    logic [SW-1:0]     wstreak_d;

    logic run;
    logic rd_can;
    logic read_win;
    logic wr_gnt;
    logic rd_gnt;

    // Grant selection: one grant per cycle, write first unless the read has starved.
    // Grants are masked while RSTB is low so the macro stays deselected in reset.
    always_comb begin
        run      = RSTB && (state == ST_RUN);
        rd_can   = (!hold_v_q && !inflight_q) || rsp_ready;
        read_win = rd_valid && rd_can && (!wr_valid || (wstreak_q == STREAK_MAX));
        rd_gnt   = run && read_win;
        wr_gnt   = run && wr_valid && !read_win;
    end

    // Macro drive: zero-fill in INIT, otherwise the current grant, idle otherwise.
    always_comb begin
        sram_ceb = 1'b1;
        sram_web = 1'b1;
        sram_a   = '0;
        sram_d   = '0;
        if (init_wr) begin
            sram_ceb = 1'b0;
            sram_web = 1'b0;
            sram_a   = init_addr;
        end else if (wr_gnt) begin
            sram_ceb = 1'b0;
            sram_web = 1'b0;
            sram_a   = wr_addr;
            sram_d   = wr_data;
        end else if (rd_gnt) begin
            sram_ceb = 1'b0;
            sram_a   = rd_addr;
        end
    end

    // Next-state for the response path and the write-streak counter.
    // Q is only ever sampled in an inflight cycle.
    always_comb begin
        inflight_d  = rd_gnt;
        hold_v_d    = hold_v_q;
        hold_data_d = hold_data_q;
        if (hold_v_q) begin
            if (rsp_ready) begin
                hold_v_d = 1'b0;
            end
        end else if (inflight_q && !rsp_ready) begin
            hold_v_d    = 1'b1;
            hold_data_d = sram_q;
        end

        wstreak_d = wstreak_q;
        if (!rd_valid || rd_gnt) begin
            wstreak_d = '0;
        end else if (wr_gnt && rd_can) begin
            wstreak_d = wstreak_q + 1'b1;
        end
    end

    // Response and arbitration registers; reset drops any read in flight or held.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            inflight_q  <= 1'b0;
            hold_v_q    <= 1'b0;
            hold_data_q <= '0;
            wstreak_q   <= '0;
        end else begin
            inflight_q  <= inflight_d;
            hold_v_q    <= hold_v_d;
            hold_data_q <= hold_data_d;
            wstreak_q   <= wstreak_d;
        end
    end

    assign wr_ready  = wr_gnt;
    assign rd_ready  = rd_gnt;
    assign rsp_valid = hold_v_q | inflight_q;
    assign rsp_data  = hold_v_q ? hold_data_q : sram_q;
    assign init_done = (state == ST_RUN);
    assign dbg_state = state;

endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// Directed testbench for sram_1rw_arbiter with a behavioural 1RW macro model.
module tb_sram_1rw_arbiter;

    localparam int DATA_W = 80;
    localparam int ADDR_W = 5;

    logic              CLK;
    logic              RSTB;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              init_done;
    logic              sram_ceb;
    logic              sram_web;
    logic [ADDR_W-1:0] sram_a;
    logic [DATA_W-1:0] sram_d;
    logic [DATA_W-1:0] sram_q;
    logic [0:0]        dbg_state;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] mem[32];

    sram_1rw_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(32), .STARVE_MAX(4)
    ) dut (
        .CLK(CLK), .RSTB(RSTB),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .init_done(init_done),
        .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_a(sram_a), .sram_d(sram_d),
        .sram_q(sram_q), .dbg_state(dbg_state)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Macro model: 1-cycle read latency, Q undefined after non-read cycles.
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 80'hDEAD_BEEF;
        sram_q = 'x;
    end
    always @(posedge CLK) begin
        if (!sram_ceb) begin
            if (!sram_web) mem[sram_a] <= sram_d;
            else           sram_q      <= mem[sram_a];
        end else begin
            sram_q <= 'x;
        end
    end

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_valid  = 1'b0;
        rd_addr   = '0;
        rsp_ready = 1'b1;
    endtask

    // One write handshake, expected to be granted immediately.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        idle_inputs();
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        #1;
        chk("wr_ready", wr_ready, 1);
        chk("wr_ceb", sram_ceb, 0);
        chk("wr_web", sram_web, 0);
        chk("wr_a", sram_a, a);
        chk("wr_d", sram_d, d);
        tick();
        idle_inputs();
    endtask

    // One read with rsp_ready=1: grant now, response the next cycle.
    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] expv);
        idle_inputs();
        rd_valid = 1'b1;
        rd_addr  = a;
        #1;
        chk("rd_ready", rd_ready, 1);
        chk("rd_ceb", sram_ceb, 0);
        chk("rd_web", sram_web, 1);
        chk("rd_a", sram_a, a);
        tick();
        idle_inputs();
        #1;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_data", rsp_data, expv);
        chk("idle_ceb", sram_ceb, 1);
        chk("idle_a", sram_a, 0);
        tick();
        chk("rsp_valid_after", rsp_valid, 0);
    endtask

`ifdef SRAM_ARB_INIT_EN
    // Zero-fill sequence from reset release: 32 writes, init_done afterwards.
    task automatic run_init();
        for (int i = 0; i < 32; i++) begin
            wr_valid = 1'b1;
            rd_valid = 1'b1;
            #1;
            chk("init_ceb", sram_ceb, 0);
            chk("init_web", sram_web, 0);
            chk("init_a", sram_a, i);
            chk("init_d", sram_d, 0);
            chk("init_done_low", init_done, 0);
            chk("init_wr_ready", wr_ready, 0);
            chk("init_rd_ready", rd_ready, 0);
            tick();
        end
        idle_inputs();
        #1;
        chk("init_done_high", init_done, 1);
        chk("init_state_run", dbg_state, 1);
    endtask
`endif

    initial begin
        int next_addr;
        int n_rsp;
        int last_cyc;

        // Reset with requests pending: nothing may reach the macro.
        RSTB = 1'b0;
        idle_inputs();
        wr_valid = 1'b1;
        rd_valid = 1'b1;
        #2;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_ceb", sram_ceb, 1);
        chk("rst_web", sram_web, 1);
`ifdef SRAM_ARB_INIT_EN
        chk("rst_init_done", init_done, 0);
`else
        chk("rst_init_done", init_done, 1);
`endif
        tick();
        tick();
        idle_inputs();
        RSTB = 1'b1;

`ifdef SRAM_ARB_INIT_EN
        run_init();
        tick();
        do_read(5'd17, 80'h0);
`else
        #1;
        chk("init_done_release", init_done, 1);
        tick();
`endif

        // Write 0xA5 to address 3, then read it back.
        do_write(5'd3, 80'hA5);
        do_read(5'd3, 80'hA5);

        // Fill addresses 0..7 with 0x100+addr for the burst.
        for (int i = 0; i < 8; i++) do_write(ADDR_W'(i), DATA_W'(32'h100 + i));

        // Burst read 0..7 with rsp_ready low on cycles 4..6.
        next_addr = 0;
        n_rsp     = 0;
        last_cyc  = -1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            rd_valid  = (next_addr < 8);
            rd_addr   = ADDR_W'(next_addr);
            rsp_ready = !(cyc >= 4 && cyc <= 6);
            #1;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) chk("burst_unexpected_rsp", 1, 0);
                else chk("burst_data", rsp_data, exp_q.pop_front());
                n_rsp++;
                last_cyc = cyc;
            end else if (rsp_valid) begin
                if (exp_q.size() == 0) chk("stall_unexpected_rsp", 1, 0);
                else chk("stall_data", rsp_data, exp_q[0]);
                chk("stall_rd_ready", rd_ready, 0);
            end
            if (rd_ready) begin
                exp_q.push_back(DATA_W'(32'h100 + next_addr));
                next_addr++;
            end
            tick();
        end
        idle_inputs();
        chk("burst_rsp_count", n_rsp, 8);
        chk("burst_last_cycle", last_cyc, 11);
        chk("burst_queue_empty", exp_q.size(), 0);
        tick();

        // Both requesters held: W,W,W,W,R repeating.
        wr_valid  = 1'b1;
        wr_addr   = 5'd20;
        wr_data   = 80'h77;
        rd_valid  = 1'b1;
        rd_addr   = 5'd21;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("starve_wr_ready", wr_ready, (i % 5) != 4);
            chk("starve_rd_ready", rd_ready, (i % 5) == 4);
            tick();
        end
        idle_inputs();
        tick();

        // Same-cycle write and read of address 5: write goes first.
        do_write(5'd5, 80'h0);
        wr_valid = 1'b1;
        wr_addr  = 5'd5;
        wr_data  = 80'h1;
        rd_valid = 1'b1;
        rd_addr  = 5'd5;
        #1;
        chk("same_wr_ready", wr_ready, 1);
        chk("same_rd_wait", rd_ready, 0);
        tick();
        wr_valid = 1'b0;
        #1;
        chk("same_rd_ready", rd_ready, 1);
        tick();
        rd_valid = 1'b0;
        #1;
        chk("same_rsp_valid", rsp_valid, 1);
        chk("same_rsp_data", rsp_data, 80'h1);
        tick();

        // Reset while a read is inflight and the consumer stalls.
        idle_inputs();
        rd_valid  = 1'b1;
        rd_addr   = 5'd5;
        rsp_ready = 1'b0;
        #1;
        chk("rstmid_rd_ready", rd_ready, 1);
        tick();
        #1;
        chk("rstmid_inflight", rsp_valid, 1);
        wr_valid = 1'b1;
        RSTB     = 1'b0;
        #1;
        chk("rstmid_rsp_valid", rsp_valid, 0);
        chk("rstmid_ceb", sram_ceb, 1);
        chk("rstmid_rd_ready_low", rd_ready, 0);
        tick();
        idle_inputs();
        RSTB = 1'b1;
`ifdef SRAM_ARB_INIT_EN
        run_init();
        tick();
        do_read(5'd5, 80'h0);
`else
        #1;
        chk("rstmid_init_done", init_done, 1);
        chk("rstmid_rsp_after", rsp_valid, 0);
        tick();
        do_read(5'd5, 80'h1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
